// File: rtl/apb_master_arbiter_pkg.sv
// apb_arb_pkg: shared types and encodings for the two-requester APB master sequencer.
// Rev 1.0
`default_nettype none

package apb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_SEL     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_SLV     = 2'd3;

  localparam logic [1:0] SEL_GPIO = 2'd1;
  localparam logic [1:0] SEL_UART = 2'd2;

  function automatic logic sel_valid(input logic [1:0] sel);
    return (sel == SEL_GPIO) || (sel == SEL_UART);
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb_master_arbiter_if.sv
// apb_master_arbiter_if: requester-side and APB-side signals of the master sequencer.
// Rev 1.0
`default_nettype none

interface apb_master_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);

  logic [1:0]             req_valid;
  logic [1:0]             req_write;
  logic [1:0][1:0]        req_sel;
  logic [1:0][ADDR_W-1:0] req_addr;
  logic [1:0][DATA_W-1:0] req_wdata;
  logic [1:0]             req_done;
  logic [DATA_W-1:0]      req_rdata;
  logic [1:0]             req_err;

  logic                   psel1;
  logic                   psel2;
  logic                   penable;
  logic                   pwrite;
  logic [ADDR_W-1:0]      paddr;
  logic [DATA_W-1:0]      pwdata;
  logic                   pready;
  logic [DATA_W-1:0]      prdata;
  logic                   pslverr;

  modport master (
    input  req_valid, req_write, req_sel, req_addr, req_wdata,
    input  pready, prdata, pslverr,
    output req_done, req_rdata, req_err,
    output psel1, psel2, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req_valid, req_write, req_sel, req_addr, req_wdata,
    output pready, prdata, pslverr,
    input  req_done, req_rdata, req_err,
    input  psel1, psel2, penable, pwrite, paddr, pwdata
  );

endinterface

`default_nettype wire

// File: rtl/apb_master_arbiter_rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin arbiter, one-hot grant, pointer favours the requester not granted last.
// Rev 1.0
`default_nettype none

module rr_arbiter_2 (
  input  wire logic       pclk,
  input  wire logic       Reset,
  input  wire logic [1:0] i_req,
  input  wire logic       i_update,
  output logic      [1:0] o_grant
);

  // r_ptr=1 means requester 1 wins a tie
  logic r_ptr;

  always_comb begin
    o_grant = i_req;
    if (i_req == 2'b11) begin
      o_grant = r_ptr ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge pclk or posedge Reset) begin
    if (Reset) begin
      r_ptr <= 1'b0;
    end else if (i_update && (|o_grant)) begin
      r_ptr <= o_grant[0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: shares one APB bus between two requesters with round-robin grant and pready timeout.
// Rev 1.0
`default_nettype none

module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input wire logic           pclk,
  input wire logic           Reset,
  apb_master_arbiter_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            r_state;
  logic              r_gidx;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_psel1;
  logic              r_psel2;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic [1:0]        r_done;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_err;

  logic              w_idle;
  logic [1:0]        w_req;
  logic [1:0]        w_grant;
  logic              w_gidx;
  logic [1:0]        w_sel;
  logic              w_write;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  // Requests only reach the arbiter in IDLE, so DONE acts as a turnaround cycle
  assign w_idle  = (r_state == ST_IDLE);
  assign w_req   = w_idle ? bus.req_valid : 2'b00;
  assign w_gidx  = w_grant[1];
  assign w_sel   = bus.req_sel[w_gidx];
  assign w_write = bus.req_write[w_gidx];
  assign w_addr  = bus.req_addr[w_gidx];
  assign w_wdata = bus.req_wdata[w_gidx];

  rr_arbiter_2 u_arb (
    .pclk     (pclk),
    .Reset    (Reset),
    .i_req    (w_req),
    .i_update (w_idle),
    .o_grant  (w_grant)
  );

  // The APB output registers double as the latched request fields
  always_ff @(posedge pclk or posedge Reset) begin
    if (Reset) begin
      r_state   <= ST_IDLE;
      r_gidx    <= 1'b0;
      r_cnt     <= '0;
      r_psel1   <= 1'b0;
      r_psel2   <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_done    <= 2'b00;
      r_rdata   <= '0;
      r_err     <= ERR_OK;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_grant) begin
            r_gidx <= w_gidx;
            if (sel_valid(w_sel)) begin
              r_state  <= ST_SETUP;
              r_psel1  <= (w_sel == SEL_GPIO);
              r_psel2  <= (w_sel == SEL_UART);
              r_pwrite <= w_write;
              r_paddr  <= w_addr;
              r_pwdata <= w_wdata;
            end else begin
              r_state <= ST_DONE;
              r_done  <= w_grant;
              r_err   <= ERR_SEL;
              r_rdata <= '0;
            end
          end
        end

        ST_SETUP: begin
          r_state   <= ST_ACCESS;
          r_penable <= 1'b1;
          r_cnt     <= '0;
        end

        ST_ACCESS: begin
          // pready wins over the terminal count when both arrive together
          if (bus.pready || (r_cnt == C_CNT_LAST)) begin
            r_state   <= ST_DONE;
            r_psel1   <= 1'b0;
            r_psel2   <= 1'b0;
            r_penable <= 1'b0;
            r_done    <= r_gidx ? 2'b10 : 2'b01;
            if (bus.pready) begin
              r_err   <= bus.pslverr ? ERR_SLV : ERR_OK;
              r_rdata <= (!r_pwrite && !bus.pslverr) ? bus.prdata : '0;
            end else begin
              r_err   <= ERR_TIMEOUT;
              r_rdata <= '0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 2'b00;
          r_err   <= ERR_OK;
          r_rdata <= '0;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.psel1     = r_psel1;
  assign bus.psel2     = r_psel2;
  assign bus.penable   = r_penable;
  assign bus.pwrite    = r_pwrite;
  assign bus.paddr     = r_paddr;
  assign bus.pwdata    = r_pwdata;
  assign bus.req_done  = r_done;
  assign bus.req_rdata = r_rdata;
  assign bus.req_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed scoreboard bench with a wait-state-programmable APB slave model.
// Rev 1.0
`default_nettype none

module tb_apb_master_arbiter;
  import apb_arb_pkg::*;

  localparam int C_TIMEOUT = 16;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic [1:0]  err;
    int          cyc;
  } exp_t;

  logic pclk;
  logic Reset;
  int   cyc;
  int   n_vec;
  int   n_err;

  exp_t        sb[$];
  logic [7:0]  addr_q[$];
  logic [31:0] wd_q[$];
  int          pen_cnt;
  logic        psel_any;

  int          slv_wait;
  int          slv_cnt;
  logic [31:0] slv_rdata;
  logic        slv_err;

  apb_master_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  apb_master_arbiter #(.ADDR_W(5), .DATA_W(32), .TIMEOUT(C_TIMEOUT)) dut (
    .pclk  (pclk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial cyc = 0;
  always @(posedge pclk) cyc = cyc + 1;

  // Slave answers on the wait-state count-th ACCESS cycle
  initial begin
    slv_cnt = 0;
    bus.pready = 1'b0;
  end
  always @(negedge pclk) begin
    if ((bus.psel1 || bus.psel2) && bus.penable) begin
      bus.pready = (slv_cnt == slv_wait);
      slv_cnt    = slv_cnt + 1;
    end else begin
      bus.pready = 1'b0;
      slv_cnt    = 0;
    end
  end
  assign bus.prdata  = slv_rdata;
  assign bus.pslverr = slv_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pop_addr();
    if (addr_q.size() == 0) return 8'hFF;
    return addr_q.pop_front();
  endfunction

  function automatic logic [31:0] pop_wd();
    if (wd_q.size() == 0) return 32'hFFFF_FFFF;
    return wd_q.pop_front();
  endfunction

  task automatic issue(input int idx, input logic wr, input logic [1:0] sel,
                       input logic [4:0] a, input logic [31:0] wd);
    bus.req_write[idx] = wr;
    bus.req_sel[idx]   = sel;
    bus.req_addr[idx]  = a;
    bus.req_wdata[idx] = wd;
    bus.req_valid[idx] = 1'b1;
  endtask

  task automatic expect_done(input int idx, input logic [31:0] rd, input logic [1:0] err, input int c);
    exp_t e;
    e.idx = idx; e.rdata = rd; e.err = err; e.cyc = c;
    sb.push_back(e);
  endtask

  // Observe at negedges until the scoreboard drains, then one settle cycle
  task automatic run(input int budget);
    exp_t e;
    for (int k = 0; k < budget && sb.size() > 0; k++) begin
      @(negedge pclk);
      if (bus.psel1 || bus.psel2) psel_any = 1'b1;
      if (bus.penable) pen_cnt++;
      if ((bus.psel1 || bus.psel2) && !bus.penable) begin
        addr_q.push_back({bus.psel2, bus.psel1, bus.pwrite, bus.paddr});
        wd_q.push_back(bus.pwdata);
      end
      if (|bus.req_done) begin
        e = sb.pop_front();
        chk("done_onehot", {30'd0, bus.req_done}, (e.idx == 1) ? 32'd2 : 32'd1);
        chk("done_rdata", bus.req_rdata, e.rdata);
        chk("done_err", {30'd0, bus.req_err}, {30'd0, e.err});
        chk("done_cycle", cyc, e.cyc);
        bus.req_valid[e.idx] = 1'b0;
      end
    end
    chk("sb_drained", sb.size(), 0);
    @(negedge pclk);
    chk("done_pulse", {30'd0, bus.req_done}, 0);
  endtask

  initial begin
    int n0;
    n_vec = 0; n_err = 0;
    pen_cnt = 0; psel_any = 1'b0;
    slv_wait = 0; slv_rdata = 32'd0; slv_err = 1'b0;
    bus.req_valid = 2'b00; bus.req_write = 2'b00; bus.req_sel = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
    Reset = 1'b1;
    repeat (3) @(negedge pclk);
    chk("rst_ctrl", {28'd0, bus.psel1, bus.psel2, bus.penable, bus.pwrite}, 0);
    chk("rst_done", {28'd0, bus.req_done, bus.req_err}, 0);
    chk("rst_rdata", bus.req_rdata, 0);
    chk("rst_paddr_pwdata", bus.pwdata | {27'd0, bus.paddr}, 0);
    Reset = 1'b0;
    @(negedge pclk);

    // Simultaneous writes: requester 0 first, then 1
    slv_wait = 0; slv_rdata = 32'hDEAD_BEEF;
    n0 = cyc + 1;
    issue(0, 1'b1, SEL_GPIO, 5'h01, 32'h1111_0001);
    issue(1, 1'b1, SEL_UART, 5'h02, 32'h2222_0002);
    expect_done(0, 32'd0, ERR_OK, n0 + 2);
    expect_done(1, 32'd0, ERR_OK, n0 + 6);
    run(40);
    chk("setup0", {24'd0, pop_addr()}, {24'd0, 8'b0_1_1_00001});
    chk("wdata0", pop_wd(), 32'h1111_0001);
    chk("setup1", {24'd0, pop_addr()}, {24'd0, 8'b1_0_1_00010});
    chk("wdata1", pop_wd(), 32'h2222_0002);

    // Read with two wait states
    slv_wait = 2; slv_rdata = 32'hA5A5_0001; pen_cnt = 0;
    n0 = cyc + 1;
    issue(0, 1'b0, SEL_UART, 5'h04, 32'd0);
    expect_done(0, 32'hA5A5_0001, ERR_OK, n0 + 4);
    run(40);
    chk("read_pen_cycles", pen_cnt, 3);
    chk("read_setup", {24'd0, pop_addr()}, {24'd0, 8'b1_0_0_00100});

    // Invalid select: immediate completion, no bus activity
    psel_any = 1'b0;
    n0 = cyc + 1;
    issue(1, 1'b0, 2'd3, 5'h0A, 32'd0);
    expect_done(1, 32'd0, ERR_SEL, n0);
    run(20);
    chk("badsel_no_psel", {31'd0, psel_any}, 0);

    // Timeout: penable high for exactly TIMEOUT cycles
    slv_wait = 1000; slv_rdata = 32'h1234_5678; pen_cnt = 0;
    n0 = cyc + 1;
    issue(0, 1'b0, SEL_GPIO, 5'h10, 32'd0);
    expect_done(0, 32'd0, ERR_TIMEOUT, n0 + 1 + C_TIMEOUT);
    run(60);
    chk("timeout_pen_cycles", pen_cnt, C_TIMEOUT);

    // pready on the terminal-count cycle is a success
    slv_wait = C_TIMEOUT - 1; slv_rdata = 32'h0F0F_0F0F; pen_cnt = 0;
    n0 = cyc + 1;
    issue(1, 1'b0, SEL_UART, 5'h07, 32'd0);
    expect_done(1, 32'h0F0F_0F0F, ERR_OK, n0 + 1 + C_TIMEOUT);
    run(60);
    chk("edge_pen_cycles", pen_cnt, C_TIMEOUT);

    // Slave error on a read
    slv_wait = 1; slv_err = 1'b1; slv_rdata = 32'h0000_ABCD;
    n0 = cyc + 1;
    issue(1, 1'b0, SEL_GPIO, 5'h1F, 32'd0);
    expect_done(1, 32'd0, ERR_SLV, n0 + 3);
    run(40);
    slv_err = 1'b0;

    // Reset during ACCESS; requester 0 was granted last
    slv_wait = 1000;
    issue(0, 1'b0, SEL_GPIO, 5'h03, 32'd0);
    for (int k = 0; k < 10 && !bus.penable; k++) @(negedge pclk);
    chk("reached_access", {31'd0, bus.penable}, 1);
    Reset = 1'b1;
    #1;
    chk("rst_async_sel_en", {29'd0, bus.psel1, bus.psel2, bus.penable}, 0);
    bus.req_valid = 2'b00;
    @(negedge pclk);
    chk("rst_no_done", {30'd0, bus.req_done}, 0);
    Reset = 1'b0;
    @(negedge pclk);
    chk("post_rst_no_done", {30'd0, bus.req_done}, 0);

    slv_wait = 0; slv_rdata = 32'h0000_0077;
    n0 = cyc + 1;
    issue(0, 1'b0, SEL_UART, 5'h05, 32'd0);
    issue(1, 1'b0, SEL_UART, 5'h06, 32'd0);
    expect_done(0, 32'h0000_0077, ERR_OK, n0 + 2);
    expect_done(1, 32'h0000_0077, ERR_OK, n0 + 6);
    addr_q.delete();
    run(40);
    chk("post_rst_first", {24'd0, pop_addr()}, {24'd0, 8'b1_0_0_00101});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
